// File: rtl/delay_pkg.sv
// Shared constants and helpers for the delayed-assignment pipe and its lanes.
package delay_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_CHANNELS  = 2;
  localparam int DEF_MAX_DELAY = 16;

  // Bit offset of a lane inside a packed multi-lane bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // A zero delay is meaningless for a registered pipe, so it becomes 1.
  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned max_delay);
    if (req == 0) begin
      return 1;
    end
    if (req > max_delay) begin
      return max_delay;
    end
    return req;
  endfunction

endpackage

// File: rtl/delay_lane.sv
// One lane: MAX_DELAY-deep valid+data shift register, tap selected by cur_delay,
// with a registered output stage and a sticky "has delivered" flag.
module delay_lane
  import delay_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_DELAY = DEF_MAX_DELAY,
  parameter int HOLD      = 1,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [DW-1:0]    cur_delay,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_seen,
  output logic             busy
);

  logic [MAX_DELAY-1:0] valid_reg;
  logic [MAX_DELAY-1:0] valid_next;
  logic [WIDTH-1:0]     data_reg [MAX_DELAY];

  logic [DW-1:0]        tap_idx;
  logic                 tap_valid;
  logic [WIDTH-1:0]     tap_data;

  logic                 out_valid_reg;
  logic [WIDTH-1:0]     out_data_reg;
  logic                 seen_reg;

  assign valid_next[0] = in_valid;

  // Entries that have passed the tap are already delivered; drop their valid
  // bit so busy tracks only undelivered data and a later, longer delay can
  // never re-deliver them.
  genvar gi;
  generate
    for (gi = 1; gi < MAX_DELAY; gi++) begin : g_stage
      assign valid_next[gi] = valid_reg[gi-1] & (DW'(gi) < cur_delay);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // Payload needs no reset: it is only observed when its valid bit is set.
  always_ff @(posedge clk) begin
    data_reg[0] <= in_data;
    for (int i = 1; i < MAX_DELAY; i++) begin
      data_reg[i] <= data_reg[i-1];
    end
  end

  assign tap_idx = cur_delay - DW'(1);

  always_comb begin
    tap_valid = 1'b0;
    tap_data  = '0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (DW'(i) == tap_idx) begin
        tap_valid = valid_reg[i];
        tap_data  = data_reg[i];
      end
    end
  end

  // Output stage adds the final cycle, so stage cur_delay-1 appears at edge t+cur_delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      seen_reg      <= 1'b0;
    end else begin
      out_valid_reg <= tap_valid;
      if (tap_valid) begin
        out_data_reg <= tap_data;
        seen_reg     <= 1'b1;
      end else if (HOLD == 0) begin
        out_data_reg <= '0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_seen  = seen_reg;
  assign busy      = |valid_reg;

endmodule

// File: rtl/delayed_assign_pipe.sv
// Multi-lane programmable-latency pipe; shared delay register and load guard,
// one delay_lane per channel.
module delayed_assign_pipe
  import delay_pkg::*;
#(
  parameter int  WIDTH     = DEF_WIDTH,
  parameter int  CHANNELS  = DEF_CHANNELS,
  parameter int  MAX_DELAY = DEF_MAX_DELAY,
  parameter int  HOLD      = 1,
  localparam int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      cfg_load,
  input  logic [DW-1:0]             cfg_delay,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_seen,
  output logic [DW-1:0]             cur_delay,
  output logic                      busy,
  output logic                      cfg_err
);

  logic [DW-1:0]       cur_delay_reg;
  logic [DW-1:0]       cur_delay_next;
  logic                cfg_err_reg;
  logic                cfg_accept;
  logic [CHANNELS-1:0] lane_busy;

  // A delay change is only safe with nothing in flight and nothing entering.
  assign cfg_accept = cfg_load & ~busy & ~(|in_valid);

  always_comb begin
    cur_delay_next = cur_delay_reg;
    if (cfg_accept) begin
      cur_delay_next = DW'(clamp_delay(32'(cfg_delay), 32'(MAX_DELAY)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_delay_reg <= DW'(1);
      cfg_err_reg   <= 1'b0;
    end else begin
      cur_delay_reg <= cur_delay_next;
      cfg_err_reg   <= cfg_load & ~cfg_accept;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      delay_lane #(
        .WIDTH     (WIDTH),
        .MAX_DELAY (MAX_DELAY),
        .HOLD      (HOLD),
        .DW        (DW)
      ) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[gi]),
        .in_data   (in_data[lane_lsb(gi, WIDTH) +: WIDTH]),
        .cur_delay (cur_delay_reg),
        .out_valid (out_valid[gi]),
        .out_data  (out_data[lane_lsb(gi, WIDTH) +: WIDTH]),
        .out_seen  (out_seen[gi]),
        .busy      (lane_busy[gi])
      );
    end
  endgenerate

  assign busy      = |lane_busy;
  assign cur_delay = cur_delay_reg;
  assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_delayed_assign_pipe.sv
// Directed bench for delayed_assign_pipe; a HOLD=1 and a HOLD=0 instance share stimulus.
module tb_delayed_assign_pipe;

  localparam int WIDTH     = 4;
  localparam int CHANNELS  = 2;
  localparam int MAX_DELAY = 16;
  localparam int DW        = $clog2(MAX_DELAY + 1);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      cfg_load;
  logic [DW-1:0]             cfg_delay;

  logic [CHANNELS-1:0]       h_out_valid, z_out_valid;
  logic [CHANNELS*WIDTH-1:0] h_out_data, z_out_data;
  logic [CHANNELS-1:0]       h_out_seen, z_out_seen;
  logic [DW-1:0]             h_cur_delay, z_cur_delay;
  logic                      h_busy, z_busy;
  logic                      h_cfg_err, z_cfg_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  delayed_assign_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DELAY(MAX_DELAY), .HOLD(1)) dut_hold (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .cfg_load(cfg_load), .cfg_delay(cfg_delay),
    .out_valid(h_out_valid), .out_data(h_out_data), .out_seen(h_out_seen),
    .cur_delay(h_cur_delay), .busy(h_busy), .cfg_err(h_cfg_err)
  );

  delayed_assign_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DELAY(MAX_DELAY), .HOLD(0)) dut_zero (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .cfg_load(cfg_load), .cfg_delay(cfg_delay),
    .out_valid(z_out_valid), .out_data(z_out_data), .out_seen(z_out_seen),
    .cur_delay(z_cur_delay), .busy(z_busy), .cfg_err(z_cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_delay(input logic [DW-1:0] d);
    cfg_load  = 1'b1;
    cfg_delay = d;
    step();
    cfg_load  = 1'b0;
  endtask

  logic [3:0] lo, hi;
  logic [1:0] exp_v;
  logic [7:0] exp_d;

  initial begin
    rst_n     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    cfg_load  = 1'b0;
    cfg_delay = '0;

    // Asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(h_out_valid), 32'h0);
    check("rst_out_data",  32'(h_out_data),  32'h0);
    check("rst_out_seen",  32'(h_out_seen),  32'h0);
    check("rst_busy",      32'(h_busy),      32'h0);
    check("rst_cfg_err",   32'(h_cfg_err),   32'h0);
    check("rst_cur_delay", 32'(h_cur_delay), 32'h1);
    check("rst_z_out_data", 32'(z_out_data), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Delay clamping while idle
    cfg_load = 1'b1; cfg_delay = 5'd0;
    step();
    check("clamp0_cur", 32'(h_cur_delay), 32'd1);
    check("clamp0_err", 32'(h_cfg_err), 32'd0);
    cfg_delay = 5'd20;
    step();
    check("clamp20_cur", 32'(h_cur_delay), 32'd16);
    check("clamp20_err", 32'(h_cfg_err), 32'd0);
    cfg_delay = 5'd10;
    step();
    cfg_load = 1'b0;
    check("load10_cur", 32'(h_cur_delay), 32'd10);
    check("load10_err", 32'(h_cfg_err), 32'd0);

    // Single sample at delay 10
    in_valid = 2'b01; in_data = 8'h05;
    step();
    in_valid = 2'b00; in_data = 8'h00;
    check("lat_busy_rise", 32'(h_busy), 32'd1);
    check("lat_seen_e0", 32'(h_out_seen), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("lat_valid_e%0d", k), 32'(h_out_valid), (k == 10) ? 32'h1 : 32'h0);
      if (k == 1) check("lat_seen_e1", 32'(h_out_seen), 32'h0);
    end
    check("lat_h_data",  32'(h_out_data), 32'h05);
    check("lat_z_data",  32'(z_out_data), 32'h05);
    check("lat_seen",    32'(h_out_seen), 32'h1);
    check("lat_busy_fall", 32'(h_busy), 32'h0);
    step();
    check("lat_valid_e11", 32'(h_out_valid), 32'h0);
    check("hold1_data",  32'(h_out_data), 32'h05);
    check("hold0_data",  32'(z_out_data), 32'h00);
    check("seen_sticky", 32'(h_out_seen), 32'h1);

    // Rejected loads: same-cycle write, then while busy
    in_valid = 2'b10; in_data = 8'hA0; cfg_load = 1'b1; cfg_delay = 5'd3;
    step();
    in_valid = 2'b00; in_data = 8'h00;
    check("rej_inval_err", 32'(h_cfg_err), 32'h1);
    check("rej_inval_cur", 32'(h_cur_delay), 32'd10);
    step();
    cfg_load = 1'b0;
    check("rej_busy_err", 32'(h_cfg_err), 32'h1);
    check("rej_busy_cur", 32'(h_cur_delay), 32'd10);
    step();
    check("rej_err_clear", 32'(h_cfg_err), 32'h0);
    check("rej_cur_keep", 32'(h_cur_delay), 32'd10);
    for (int k = 3; k <= 10; k++) begin
      step();
      check($sformatf("rej_valid_e%0d", k), 32'(h_out_valid), (k == 10) ? 32'h2 : 32'h0);
    end
    check("rej_h_data", 32'(h_out_data), 32'hA5);
    check("rej_z_data", 32'(z_out_data), 32'hA0);
    check("rej_seen",   32'(h_out_seen), 32'h3);
    check("rej_busy",   32'(h_busy), 32'h0);

    // Full pipe at MAX_DELAY
    load_delay(5'd16);
    check("full_cur", 32'(h_cur_delay), 32'd16);
    for (int e = 0; e < 34; e++) begin
      if (e < 16) begin
        lo = 4'(e); hi = 4'(15 - e);
        in_valid = 2'b11; in_data = {hi, lo};
      end else begin
        in_valid = 2'b00; in_data = 8'h00;
      end
      step();
      if (e >= 16 && e < 32) begin
        lo = 4'(e - 16); hi = 4'(31 - e);
        check($sformatf("full_valid_e%0d", e), 32'(h_out_valid), 32'h3);
        check($sformatf("full_data_e%0d", e), 32'(h_out_data), 32'({hi, lo}));
      end else begin
        check($sformatf("full_valid_e%0d", e), 32'(h_out_valid), 32'h0);
      end
      check($sformatf("full_busy_e%0d", e), 32'(h_busy), (e <= 30) ? 32'h1 : 32'h0);
    end

    // Alternating lanes at delay 2, zero-when-idle instance
    load_delay(5'd2);
    check("alt_cur", 32'(h_cur_delay), 32'd2);
    for (int e = 0; e < 9; e++) begin
      if (e < 6) begin
        if (e % 2 == 0) begin
          lo = 4'(e + 1); in_valid = 2'b01; in_data = {4'hF, lo};
        end else begin
          hi = 4'(e + 8); in_valid = 2'b10; in_data = {hi, 4'hF};
        end
      end else begin
        in_valid = 2'b00; in_data = 8'h00;
      end
      step();
      exp_v = 2'b00; exp_d = 8'h00;
      if (e >= 2 && e < 8) begin
        if ((e - 2) % 2 == 0) begin
          lo = 4'(e - 1); exp_v = 2'b01; exp_d = {4'h0, lo};
        end else begin
          hi = 4'(e + 6); exp_v = 2'b10; exp_d = {hi, 4'h0};
        end
      end
      check($sformatf("alt_valid_e%0d", e), 32'(z_out_valid), 32'(exp_v));
      check($sformatf("alt_data_e%0d", e), 32'(z_out_data), 32'(exp_d));
    end
    check("alt_hold_data", 32'(h_out_data), 32'hD5);

    // Reset with five entries in flight
    load_delay(5'd10);
    for (int e = 0; e < 5; e++) begin
      lo = 4'(e + 3);
      in_valid = 2'b01; in_data = {4'h0, lo};
      step();
    end
    in_valid = 2'b00; in_data = 8'h00;
    check("mid_busy", 32'(h_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(h_busy), 32'h0);
    check("mid_rst_valid", 32'(h_out_valid), 32'h0);
    check("mid_rst_seen",  32'(h_out_seen), 32'h0);
    check("mid_rst_cur",   32'(h_cur_delay), 32'h1);
    check("mid_rst_data",  32'(h_out_data), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    in_valid = 2'b10; in_data = 8'h70;
    step();
    in_valid = 2'b00; in_data = 8'h00;
    check("post_rst_accept", 32'(h_busy), 32'h1);
    step();
    check("post_rst_valid", 32'(h_out_valid), 32'h2);
    check("post_rst_data",  32'(h_out_data), 32'h70);
    check("post_rst_seen",  32'(h_out_seen), 32'h2);
    for (int k = 0; k < 15; k++) begin
      step();
      check($sformatf("post_rst_quiet_%0d", k), 32'(h_out_valid), 32'h0);
    end
    check("post_rst_seen_end", 32'(h_out_seen), 32'h2);
    check("post_rst_busy_end", 32'(h_busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
